// File: rtl/gs_butterfly_if.sv
`timescale 1ns/1ps
// Handshake bus for the Gentleman-Sande butterfly: operand side and result side.
interface gs_butterfly_if #(
  parameter int data_width = 14
);
  logic                  in_valid;
  logic                  in_ready;
  logic [data_width-1:0] a;
  logic [data_width-1:0] b;
  logic [data_width-1:0] w;
  logic                  half_en;
  logic                  out_valid;
  logic                  out_ready;
  logic [data_width-1:0] x;
  logic [data_width-1:0] y;

  // Producer/consumer side (drives operands, accepts results).
  modport master (
    output in_valid, a, b, w, half_en, out_ready,
    input  in_ready, out_valid, x, y
  );

  // Butterfly side.
  modport slave (
    input  in_valid, a, b, w, half_en, out_ready,
    output in_ready, out_valid, x, y
  );
endinterface

// File: rtl/gs_butterfly.sv
`timescale 1ns/1ps
// Inverse-NTT Gentleman-Sande butterfly, 4-stage pipeline:
//   x = (a + b) mod q,  y = ((a - b) mod q) * w mod q, optional halving mod q.
// S1 add/sub, S2 multiply, S3 Barrett estimate, S4 final correction + halving.
// A single global advance (en) stalls the whole pipe when the output is held.
module gs_butterfly #(
  parameter int                    data_width = 14,
  parameter logic [data_width-1:0] M          = 14'd12289
)(
  input  logic         clk,
  input  logic         rst,
  gs_butterfly_if.slave bus
);
  localparam int              DW = data_width;
  localparam int              BK = 2 * DW;                     // Barrett shift k
  localparam logic [63:0]     BM = (64'd1 << BK) / 64'(M);     // floor(2^k / q)
  localparam logic [DW:0]     QW = {1'b0, M};
  localparam logic [DW+1:0]   QR = {2'b00, M};

  // (v even) ? v/2 : (v+q)/2  -- multiplication by 2^-1 mod q
  function automatic logic [DW-1:0] halve(input logic [DW-1:0] v);
    logic [DW:0] s;
    s = {1'b0, v} + (v[0] ? QW : '0);
    return DW'(s >> 1);
  endfunction

  logic        en, accept;
  logic [4:1]  vld_q;

  assign en            = bus.out_ready || !vld_q[4];
  assign accept        = bus.in_valid && en;
  assign bus.in_ready  = en;
  assign bus.out_valid = vld_q[4];

  // S1 next-state: modular add and subtract, one correction each
  logic [DW:0]   sum, dif;
  logic [DW-1:0] s1_x_d, s1_d_d;
  always_comb begin
    sum    = {1'b0, bus.a} + {1'b0, bus.b};
    dif    = {1'b0, bus.a} - {1'b0, bus.b};
    s1_x_d = (sum >= QW) ? DW'(sum - QW) : DW'(sum);
    s1_d_d = dif[DW] ? DW'(dif + QW) : DW'(dif);
  end

  logic [DW-1:0] s1_x_q, s1_d_q, s1_w_q;
  logic          s1_h_q;
  // S1 registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_x_q <= '0; s1_d_q <= '0; s1_w_q <= '0; s1_h_q <= 1'b0;
    end else if (en) begin
      s1_x_q <= s1_x_d; s1_d_q <= s1_d_d; s1_w_q <= bus.w; s1_h_q <= bus.half_en;
    end
  end

  logic [BK-1:0] s2_p_d, s2_p_q;
  logic [DW-1:0] s2_x_q;
  logic          s2_h_q;
  assign s2_p_d = BK'(s1_d_q) * BK'(s1_w_q);
  // S2 registers: full-width product
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_p_q <= '0; s2_x_q <= '0; s2_h_q <= 1'b0;
    end else if (en) begin
      s2_p_q <= s2_p_d; s2_x_q <= s1_x_q; s2_h_q <= s1_h_q;
    end
  end

  // S3 next-state: Barrett quotient estimate and raw remainder (< 3q)
  logic [BK-1:0]   qhat;
  logic [DW+1:0]   s3_r_d;
  always_comb begin
    qhat   = BK'((64'(s2_p_q) * BM) >> BK);
    s3_r_d = (DW+2)'(64'(s2_p_q) - 64'(qhat) * 64'(M));
  end

  logic [DW+1:0] s3_r_q;
  logic [DW-1:0] s3_x_q;
  logic          s3_h_q;
  // S3 registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s3_r_q <= '0; s3_x_q <= '0; s3_h_q <= 1'b0;
    end else if (en) begin
      s3_r_q <= s3_r_d; s3_x_q <= s2_x_q; s3_h_q <= s2_h_q;
    end
  end

  // S4 next-state: up to two subtractions of q, then optional halving
  logic [DW+1:0] r1, r2;
  logic [DW-1:0] x_d, y_d;
  always_comb begin
    r1  = (s3_r_q >= QR) ? s3_r_q - QR : s3_r_q;
    r2  = (r1 >= QR) ? r1 - QR : r1;
    x_d = s3_h_q ? halve(s3_x_q) : s3_x_q;
    y_d = s3_h_q ? halve(DW'(r2)) : DW'(r2);
  end

  logic [DW-1:0] x_q, y_q;
  // S4 output registers; held while the consumer stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q <= '0; y_q <= '0;
    end else if (en) begin
      x_q <= x_d; y_q <= y_d;
    end
  end
  assign bus.x = x_q;
  assign bus.y = y_q;

  // Valid shift register; a bubble enters whenever nothing is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     vld_q <= '0;
    else if (en) vld_q <= {vld_q[3:1], accept};
  end
endmodule

// File: tb/tb_gs_butterfly.sv
`timescale 1ns/1ps
module tb_gs_butterfly;
  localparam int Q    = 12289;
  localparam int HALF = 6145;     // 2^-1 mod q

  typedef struct { int x; int y; int cyc; } exp_t;

  logic clk, rst;
  gs_butterfly_if #(.data_width(14)) bus();

  gs_butterfly #(.data_width(14), .M(14'd12289)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_pass = 0, n_total = 0, n_fail = 0;
  int   cyc = 0;
  bit   acc, lat_chk, rand_ordy, prev_stall;
  int   nx, ny;
  logic [13:0] px, py;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Reference: plain modular arithmetic; halving as multiplication by 2^-1.
  function automatic void model(input int a, b, w, h, output int ex, ey);
    int d;
    ex = (a + b) % Q;
    d  = (a - b + Q) % Q;
    ey = (d * w) % Q;
    if (h != 0) begin
      ex = (ex * HALF) % Q;
      ey = (ey * HALF) % Q;
    end
  endfunction

  // One clock: called just after a falling edge with inputs already driven.
  task automatic tick();
    exp_t e;
    if (rand_ordy) bus.out_ready = 1'($urandom_range(0, 1));
    #1;
    if (prev_stall && bus.out_valid) begin
      chk("stall_x", 32'(bus.x), 32'(px));
      chk("stall_y", 32'(bus.y), 32'(py));
    end
    if (!bus.in_ready) chk("in_ready_low_only_on_stall", 32'(bus.out_valid && !bus.out_ready), 1);
    if (bus.out_ready) chk("in_ready_with_out_ready", 32'(bus.in_ready), 1);
    if (bus.out_valid && bus.out_ready) begin
      chk("out_has_pending", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("x", 32'(bus.x), e.x);
        chk("y", 32'(bus.y), e.y);
        if (lat_chk) chk("latency", cyc - e.cyc, 4);
      end
    end
    prev_stall = bus.out_valid && !bus.out_ready;
    px = bus.x;
    py = bus.y;
    acc = bus.in_valid && bus.in_ready;
    if (acc) exp_q.push_back('{nx, ny, cyc});
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic send(input int a, b, w, h, ex, ey);
    int g = 0;
    bus.a = 14'(a); bus.b = 14'(b); bus.w = 14'(w); bus.half_en = 1'(h);
    bus.in_valid = 1'b1;
    nx = ex; ny = ey;
    do begin tick(); g++; end while (!acc && g < 200);
    if (!acc) chk("accept_timeout", 32'(acc), 1);
  endtask

  task automatic send_m(input int a, b, w, h);
    int ex, ey;
    model(a, b, w, h, ex, ey);
    send(a, b, w, h, ex, ey);
  endtask

  task automatic drain();
    int g = 0;
    bus.in_valid = 1'b0;
    while (exp_q.size() > 0 && g < 300) begin tick(); g++; end
    chk("drain", exp_q.size(), 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int wv, a, b;
    clk = 1'b0; rst = 1'b1;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.w = '0; bus.half_en = 1'b0;
    bus.out_ready = 1'b1;
    lat_chk = 1'b1; rand_ordy = 1'b0; prev_stall = 1'b0;

    // Reset state
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_x", 32'(bus.x), 0);
    chk("rst_y", 32'(bus.y), 0);
    rst = 1'b0;
    #1 chk("in_ready_after_rst", 32'(bus.in_ready), 1);
    @(negedge clk);

    // Directed vectors; first op also checks post-reset latency
    send(5, 3, 1, 0, 8, 2);
    drain();
    send(3, 5, 1, 0, 8, 12287);
    send(12288, 12288, 12288, 0, 12287, 0);
    send(12288, 0, 12288, 0, 12288, 1);
    send(12288, 0, 12288, 1, 6144, 6145);
    send(1, 0, 1, 1, 6145, 6145);
    drain();

    // Random stream with random backpressure
    lat_chk = 1'b0; rand_ordy = 1'b1;
    for (int i = 0; i < 16; i++)
      send_m($urandom_range(0, Q-1), $urandom_range(0, Q-1), $urandom_range(0, Q-1),
             $urandom_range(0, 1));
    drain();
    rand_ordy = 1'b0; bus.out_ready = 1'b1; lat_chk = 1'b1;
    tick();

    // Mid-flight reset discards everything in the pipe
    for (int i = 0; i < 3; i++)
      send_m($urandom_range(0, Q-1), $urandom_range(0, Q-1), $urandom_range(0, Q-1), 0);
    bus.in_valid = 1'b0;
    tick();
    tick();
    exp_q.delete();
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 0);
    chk("midrst_x", 32'(bus.x), 0);
    chk("midrst_y", 32'(bus.y), 0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0; prev_stall = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1 chk("post_rst_quiet", 32'(bus.out_valid), 0);
      tick();
    end
    send_m(100, 7000, 4321, 1);
    drain();

    // Sweep every difference d with several twiddles
    for (int s = 0; s < 5; s++) begin
      for (int d = 0; d < Q; d++) begin
        case (s)
          0: wv = 0;
          1: wv = 1;
          2: wv = 2;
          3: wv = Q - 1;
          default: wv = $urandom_range(0, Q-1);
        endcase
        b = $urandom_range(0, Q-1);
        a = (b + d) % Q;
        send_m(a, b, wv, 0);
      end
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
